range_tx: RTL and testbench

- Downstream stage of the range-finder chip. Captures each finished 10-bit range result together with its error flag.
- Buffers captured results in a small FIFO and transmits them on a single-wire framed serial output for off-chip readback.
- Lets the tester read many range results without sampling the parallel io_out bus.

---
 rtl/range_tx_if.sv | 29 ++
 rtl/range_tx.sv | 172 +++++++++++++++++
 tb/tb_range_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/range_tx_if.sv
// Range readback bus: captured range results in, framed serial line and FIFO status out.
interface range_tx_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] range_in;
  logic             error_in;
  logic             capture;
  logic             tx_en;
  logic             tx_out;
  logic             busy;
  logic [CW-1:0]    count;
  logic             fifo_full;
  logic             overflow;

  // Drives range results and transmit permission; observes the serial line and status.
  modport master (
    output range_in, error_in, capture, tx_en,
    input  tx_out, busy, count, fifo_full, overflow
  );

  // The transmitter side.
  modport slave (
    input  range_in, error_in, capture, tx_en,
    output tx_out, busy, count, fifo_full, overflow
  );
endinterface

// File: rtl/range_tx.sv
// Captures finished range results into a small FIFO and sends each one as a serial frame:
// start(0), WIDTH data bits LSB first, error bit, even parity bit, stop(1).
module range_tx #(
  parameter int unsigned WIDTH        = 10,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  range_tx_if.slave  bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
  localparam logic [BW-1:0] BIT_LAST   = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StErr,
    StParity,
    StStop
  } state_e;

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH:0]   r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_capture_q;

  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic             r_par;
  logic [BW-1:0]    r_bit_cnt;
  logic [IW-1:0]    r_idx;

  logic             w_push;
  logic             w_pop;
  logic             w_accept;
  logic             w_full;
  logic             w_bit_done;
  logic             w_can_start;
  logic [WIDTH:0]   w_head;

  assign w_push      = bus.capture & ~r_capture_q;
  assign w_full      = (r_count == COUNT_FULL);
  // A push into a full FIFO still lands if the head is leaving in the same cycle.
  assign w_accept    = w_push & (~w_full | w_pop);
  assign w_bit_done  = (r_bit_cnt == BIT_LAST);
  assign w_can_start = (r_count != '0) & bus.tx_en;
  assign w_head      = r_mem[r_rptr];

  assign bus.busy      = (r_state != StIdle);
  assign bus.count     = r_count;
  assign bus.fifo_full = w_full;
  assign bus.overflow  = r_overflow;

  // Frame sequencing; popping the FIFO is tied to leaving IDLE or chaining out of STOP.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_can_start) begin
          w_state_next = StStart;
          w_pop        = 1'b1;
        end
      end
      StStart:  if (w_bit_done) w_state_next = StData;
      StData:   if (w_bit_done && (r_idx == IDX_LAST)) w_state_next = StErr;
      StErr:    if (w_bit_done) w_state_next = StParity;
      StParity: if (w_bit_done) w_state_next = StStop;
      StStop: begin
        if (w_bit_done) begin
          if (w_can_start) begin
            w_state_next = StStart;
            w_pop        = 1'b1;
          end else begin
            w_state_next = StIdle;
          end
        end
      end
      default:  w_state_next = StIdle;
    endcase
  end

  // Serial line value decoded from the current state; idles high.
  always_comb begin
    bus.tx_out = 1'b1;
    unique case (r_state)
      StStart:  bus.tx_out = 1'b0;
      StData:   bus.tx_out = r_data[0];
      StErr:    bus.tx_out = r_err;
      StParity: bus.tx_out = r_par;
      default:  bus.tx_out = 1'b1;
    endcase
  end

  // State register plus bit-time and bit-index counters, cleared on every state entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_idx     <= '0;
    end else begin
      r_state <= w_state_next;
      // Every non-IDLE transition happens on a bit-done cycle, so this also covers entry.
      if ((r_state == StIdle) || w_bit_done) begin
        r_bit_cnt <= '0;
      end else begin
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
      if ((w_state_next != StData) || (r_state != StData)) begin
        r_idx <= '0;
      end else if (w_bit_done) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  // Shift register: loaded from the FIFO head on pop, shifted after each data bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_err  <= 1'b0;
      r_par  <= 1'b0;
    end else if (w_pop) begin
      r_data <= w_head[WIDTH-1:0];
      r_err  <= w_head[WIDTH];
      r_par  <= ^w_head;
    end else if ((r_state == StData) && w_bit_done) begin
      r_data <= r_data >> 1;
    end
  end

  // FIFO bookkeeping: capture edge detect, pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_capture_q <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_capture_q <= bus.capture;
      if (w_accept) r_wptr <= r_wptr + PW'(1);
      if (w_pop)    r_rptr <= r_rptr + PW'(1);
      unique case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_wptr] <= {bus.error_in, bus.range_in};
  end

endmodule

// File: tb/tb_range_tx.sv
// Directed bench for range_tx: frame timing, FIFO overflow, level capture, parity,
// tx_en gating and asynchronous reset mid-frame.
module tb_range_tx;
  localparam int unsigned WIDTH      = 10;
  localparam int unsigned DEPTH      = 4;
  localparam int unsigned CPB        = 4;
  localparam int unsigned FRAME_BITS = WIDTH + 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_asserts = 0;
  int   n_fail    = 0;

  range_tx_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  range_tx #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on the first START cycle; walks every cycle of one frame. exp[0] is sent first.
  task automatic check_frame(input string tag, input logic [FRAME_BITS-1:0] exp);
    for (int i = 0; i < int'(FRAME_BITS * CPB); i++) begin
      chk($sformatf("%s tx_out cyc%0d", tag, i), 32'(bus.tx_out), 32'(exp[i / CPB]));
      chk($sformatf("%s busy cyc%0d", tag, i), 32'(bus.busy), 32'd1);
      tick();
    end
  endtask

  task automatic pulse(input logic [WIDTH-1:0] r, input logic e);
    bus.range_in = r;
    bus.error_in = e;
    bus.capture  = 1'b1;
    tick();
    bus.capture  = 1'b0;
    bus.error_in = 1'b0;
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(bus.busy), 32'd0);
    chk({tag, " tx_out"}, 32'(bus.tx_out), 32'd1);
  endtask

  initial begin
    bus.range_in = '0;
    bus.error_in = 1'b0;
    bus.capture  = 1'b0;
    bus.tx_en    = 1'b0;

    // Reset state, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset count", 32'(bus.count), 32'd0);
    chk("reset fifo_full", 32'(bus.fifo_full), 32'd0);
    chk("reset overflow", 32'(bus.overflow), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single frame 0x2A5: tx_out falls one cycle after the capture edge.
    bus.tx_en    = 1'b1;
    bus.range_in = 10'h2A5;
    bus.capture  = 1'b1;
    tick();
    chk("single count after push", 32'(bus.count), 32'd1);
    chk_idle("single before start");
    bus.capture = 1'b0;
    tick();
    chk("single count after pop", 32'(bus.count), 32'd0);
    check_frame("single", {1'b1, 1'b1, 1'b0, 10'b1010100101, 1'b0});
    chk_idle("single after");
    chk("single count end", 32'(bus.count), 32'd0);

    // Overflow: five captures into a four-deep FIFO with transmit blocked.
    bus.tx_en = 1'b0;
    for (int k = 1; k <= 5; k++) pulse(10'(k), 1'b0);
    chk("ovf count", 32'(bus.count), 32'd4);
    chk("ovf fifo_full", 32'(bus.fifo_full), 32'd1);
    chk("ovf overflow", 32'(bus.overflow), 32'd1);
    chk_idle("ovf blocked");
    bus.tx_en = 1'b1;
    tick();
    chk("ovf count f1", 32'(bus.count), 32'd3);
    check_frame("ovf f1", {1'b1, 1'b1, 1'b0, 10'h001, 1'b0});
    chk("ovf count f2", 32'(bus.count), 32'd2);
    check_frame("ovf f2", {1'b1, 1'b1, 1'b0, 10'h002, 1'b0});
    chk("ovf count f3", 32'(bus.count), 32'd1);
    check_frame("ovf f3", {1'b1, 1'b0, 1'b0, 10'h003, 1'b0});
    chk("ovf count f4", 32'(bus.count), 32'd0);
    check_frame("ovf f4", {1'b1, 1'b1, 1'b0, 10'h004, 1'b0});
    chk_idle("ovf after");
    chk("ovf overflow sticky", 32'(bus.overflow), 32'd1);
    chk("ovf fifo_full clear", 32'(bus.fifo_full), 32'd0);

    // Level capture: 20 high cycles, changing data, one entry holding the first value.
    bus.tx_en    = 1'b0;
    bus.capture  = 1'b1;
    bus.range_in = 10'h100;
    for (int i = 1; i < 20; i++) begin
      tick();
      bus.range_in = 10'(32'h100 + i);
    end
    tick();
    bus.capture = 1'b0;
    tick();
    tick();
    chk("level count", 32'(bus.count), 32'd1);
    bus.tx_en = 1'b1;
    tick();
    check_frame("level", {1'b1, 1'b1, 1'b0, 10'h100, 1'b0});
    chk_idle("level after");
    chk("level count end", 32'(bus.count), 32'd0);

    // Error flag with all-zero data: error bit 1, parity bit 1.
    pulse(10'h000, 1'b1);
    check_frame("errpar", {1'b1, 1'b1, 1'b1, 10'h000, 1'b0});
    chk_idle("errpar after");

    // tx_en dropped mid-frame: the frame finishes, the second waits for tx_en.
    bus.tx_en = 1'b0;
    pulse(10'h3FF, 1'b0);
    pulse(10'h001, 1'b1);
    chk("txen count queued", 32'(bus.count), 32'd2);
    bus.tx_en = 1'b1;
    tick();
    bus.tx_en = 1'b0;
    chk("txen count f1", 32'(bus.count), 32'd1);
    check_frame("txen f1", {1'b1, 1'b0, 1'b0, 10'h3FF, 1'b0});
    chk_idle("txen held");
    chk("txen count held", 32'(bus.count), 32'd1);
    tick();
    tick();
    tick();
    chk_idle("txen still held");
    bus.tx_en = 1'b1;
    tick();
    chk("txen count f2", 32'(bus.count), 32'd0);
    check_frame("txen f2", {1'b1, 1'b0, 1'b1, 10'h001, 1'b0});
    chk_idle("txen after");

    // Asynchronous reset during DATA with three entries queued.
    bus.tx_en = 1'b0;
    pulse(10'h0AB, 1'b0);
    pulse(10'h0BB, 1'b0);
    pulse(10'h0CC, 1'b0);
    chk("rst count queued", 32'(bus.count), 32'd3);
    bus.tx_en = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) tick();
    chk("rst busy in data", 32'(bus.busy), 32'd1);
    chk("rst data bit0", 32'(bus.tx_out), 32'd1);
    chk("rst overflow before", 32'(bus.overflow), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_idle("rst async");
    chk("rst async count", 32'(bus.count), 32'd0);
    chk("rst async overflow", 32'(bus.overflow), 32'd0);
    chk("rst async fifo_full", 32'(bus.fifo_full), 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ((i % 5) == 4) begin
        chk_idle($sformatf("rst quiet cyc%0d", i));
        chk($sformatf("rst quiet count cyc%0d", i), 32'(bus.count), 32'd0);
      end
    end
    pulse(10'h123, 1'b0);
    check_frame("rst new", {1'b1, 1'b0, 1'b0, 10'h123, 1'b0});
    chk_idle("rst new after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
